// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by the socket and its bench.
package tlul_pkg;

    parameter int unsigned TL_AW  = 32;
    parameter int unsigned TL_DW  = 32;
    parameter int unsigned TL_AIW = 8;
    parameter int unsigned TL_DIW = 1;
    parameter int unsigned TL_SZW = 2;
    parameter int unsigned TL_DBW = TL_DW / 8;
    parameter int unsigned TL_UW  = 16;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_UW-1:0]  a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_UW-1:0]  d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_socket_m1_rr.sv
// M:1 TL-UL socket with locked round-robin arbitration. The host index is
// appended to the low bits of a_source and used to route responses back.
// Optional macro TLUL_SOCKET_M1_RSP_REG_EN adds a one-entry response register.
module tlul_socket_m1_rr #(
    parameter int unsigned M = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tlul_pkg::tl_h2d_t  tl_h_i [M],
    output tlul_pkg::tl_d2h_t  tl_h_o [M],
    output tlul_pkg::tl_h2d_t  tl_d_o,
    input  tlul_pkg::tl_d2h_t  tl_d_i,
    output logic [M-1:0]       gnt_o,
    output logic               rsp_misroute_o
);

    localparam int unsigned SW  = $clog2(M);
    localparam int unsigned AIW = tlul_pkg::TL_AIW;

    // Arbiter state
    logic [SW-1:0]     r_prio;
    logic              r_lock;
    logic [SW-1:0]     r_lock_id;

    logic              w_gnt_any;
    logic [SW-1:0]     w_gnt_id;
    logic [M-1:0]      w_gnt;
    tlul_pkg::tl_h2d_t w_req;
    logic              w_a_valid;
    logic              w_accept;

    // Response path
    tlul_pkg::tl_d2h_t w_rsp;
    logic              w_rsp_valid;
    logic [SW-1:0]     w_route_idx;
    logic              w_route_ok;
    logic              w_route_ready;
    logic              w_dev_d_ready;
    logic              w_misroute;

    // Top source bits are discarded by design
    logic              w_unused;
    assign w_unused = ^w_req.a_source[AIW-1 -: SW];

    // Pick the granted host: locked id first, else first valid from r_prio upward
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        if (!rst_i) begin
            if (r_lock) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = r_lock_id;
            end else begin
                // Scan backwards so the closest valid host to r_prio wins last
                for (int k = int'(M) - 1; k >= 0; k--) begin
                    if (tl_h_i[(int'(r_prio) + k) % int'(M)].a_valid) begin
                        w_gnt_any = 1'b1;
                        w_gnt_id  = SW'((int'(r_prio) + k) % int'(M));
                    end
                end
            end
        end
    end

    // One-hot grant vector and request mux
    always_comb begin
        w_gnt = '0;
        w_req = '0;
        for (int i = 0; i < int'(M); i++) begin
            if (w_gnt_any && (w_gnt_id == SW'(i))) begin
                w_gnt[i] = 1'b1;
                w_req    = tl_h_i[i];
            end
        end
    end

    assign w_a_valid = w_gnt_any & w_req.a_valid;
    assign w_accept  = w_a_valid & tl_d_i.a_ready;
    assign gnt_o     = w_gnt;

    // Device request: granted host passes through with its index tagged on a_source
    always_comb begin
        tl_d_o          = w_req;
        tl_d_o.a_valid  = w_a_valid;
        tl_d_o.a_source = {w_req.a_source[AIW-1-SW:0], w_gnt_id};
        tl_d_o.d_ready  = w_dev_d_ready;
    end

    // Lock a stalled grant; advance priority past the host on accept
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio    <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_accept) begin
            r_lock <= 1'b0;
            r_prio <= (w_gnt_id == SW'(M - 1)) ? '0 : w_gnt_id + SW'(1);
        end else if (w_a_valid) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_gnt_id;
        end
    end

    // Destination of the beat currently presented to hosts
    assign w_route_idx = w_rsp.d_source[SW-1:0];
    assign w_route_ok  = ({1'b0, w_route_idx} < (SW + 1)'(M));

    // d_ready of the host the presented beat is routed to; sink misrouted beats
    always_comb begin
        w_route_ready = 1'b1;
        if (w_route_ok) begin
            w_route_ready = 1'b0;
            for (int i = 0; i < int'(M); i++) begin
                if (w_route_idx == SW'(i)) begin
                    w_route_ready = tl_h_i[i].d_ready;
                end
            end
        end
    end

`ifdef TLUL_SOCKET_M1_RSP_REG_EN
    logic              r_full;
    tlul_pkg::tl_d2h_t r_rsp;
    logic              w_in_ok;
    logic              w_capture;

    assign w_rsp         = r_rsp;
    assign w_rsp_valid   = r_full;
    assign w_in_ok       = ({1'b0, tl_d_i.d_source[SW-1:0]} < (SW + 1)'(M));
    // Accept a new beat in the same cycle the held one drains
    assign w_dev_d_ready = !r_full | w_route_ready;
    assign w_capture     = tl_d_i.d_valid & w_dev_d_ready;
    assign w_misroute    = w_capture & !w_in_ok & !rst_i;

    // One-entry response holding register; misrouted beats are never stored
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_full <= 1'b0;
            r_rsp  <= '0;
        end else if (w_capture && w_in_ok) begin
            r_full <= 1'b1;
            r_rsp  <= tl_d_i;
        end else if (r_full && w_route_ready) begin
            r_full <= 1'b0;
        end
    end
`else
    assign w_rsp         = tl_d_i;
    assign w_rsp_valid   = tl_d_i.d_valid;
    assign w_dev_d_ready = w_route_ready;
    assign w_misroute    = tl_d_i.d_valid & !w_route_ok & !rst_i;
`endif

    assign rsp_misroute_o = w_misroute;

    // Host response channels: only the routed host sees d_valid
    always_comb begin
        for (int i = 0; i < int'(M); i++) begin
            tl_h_o[i]          = w_rsp;
            tl_h_o[i].d_source = w_rsp.d_source >> SW;
            tl_h_o[i].d_valid  = w_rsp_valid & (w_route_idx == SW'(i)) & !rst_i;
            tl_h_o[i].a_ready  = tl_d_i.a_ready & w_gnt[i];
        end
    end

endmodule

// File: tb/tb_tlul_socket_m1_rr.sv
// Directed bench for tlul_socket_m1_rr: vector table plus hand sequences for
// lock, reset mid-stall, misroute (M=3) and registered response back-pressure.
module tb_tlul_socket_m1_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tlul_pkg::tl_h2d_t h4 [4];
    tlul_pkg::tl_d2h_t h4o [4];
    tlul_pkg::tl_h2d_t d4o;
    tlul_pkg::tl_d2h_t d4i;
    logic [3:0]        gnt4;
    logic              mis4;

    tlul_pkg::tl_h2d_t h3 [3];
    tlul_pkg::tl_d2h_t h3o [3];
    tlul_pkg::tl_h2d_t d3o;
    tlul_pkg::tl_d2h_t d3i;
    logic [2:0]        gnt3;
    logic              mis3;

    tlul_socket_m1_rr #(.M(4)) u_dut4 (
        .clk_i          (clk),
        .rst_i          (rst),
        .tl_h_i         (h4),
        .tl_h_o         (h4o),
        .tl_d_o         (d4o),
        .tl_d_i         (d4i),
        .gnt_o          (gnt4),
        .rsp_misroute_o (mis4)
    );

    tlul_socket_m1_rr #(.M(3)) u_dut3 (
        .clk_i          (clk),
        .rst_i          (rst),
        .tl_h_i         (h3),
        .tl_h_o         (h3o),
        .tl_d_o         (d3o),
        .tl_d_i         (d3i),
        .gnt_o          (gnt3),
        .rsp_misroute_o (mis3)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  hv;
        logic        ar;
        logic        dv;
        logic [7:0]  ds;
        logic [3:0]  hdr;
        logic [3:0]  e_gnt;
        logic        e_aval;
        logic [7:0]  e_asrc;
        logic [31:0] e_addr;
        logic [3:0]  e_hdv;
        logic        e_dready;
        logic [7:0]  e_hds;
    } vec_t;

    vec_t vec [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive4(input logic [3:0] hv, input logic ar, input logic dv,
                          input logic [7:0] ds, input logic [3:0] hdr);
        for (int i = 0; i < 4; i++) begin
            h4[i]           = '0;
            h4[i].a_valid   = hv[i];
            h4[i].a_opcode  = 3'd4;
            h4[i].a_source  = 8'h05;
            h4[i].a_address = 32'(i) * 32'h100;
            h4[i].a_mask    = 4'hf;
            h4[i].d_ready   = hdr[i];
        end
        d4i          = '0;
        d4i.a_ready  = ar;
        d4i.d_valid  = dv;
        d4i.d_source = ds;
        d4i.d_opcode = 3'd1;
        d4i.d_data   = 32'hcafe0000 | 32'(ds);
    endtask

    task automatic drive3(input logic dv, input logic [7:0] ds, input logic [2:0] hdr);
        for (int i = 0; i < 3; i++) begin
            h3[i]         = '0;
            h3[i].d_ready = hdr[i];
        end
        d3i          = '0;
        d3i.a_ready  = 1'b1;
        d3i.d_valid  = dv;
        d3i.d_source = ds;
    endtask

    function automatic logic [3:0] ardy4();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = h4o[i].a_ready;
        return r;
    endfunction

    function automatic logic [3:0] dv4();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = h4o[i].d_valid;
        return r;
    endfunction

    function automatic logic [2:0] dv3();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = h3o[i].d_valid;
        return r;
    endfunction

    // One cycle of an M=4 request-side step with grant/a_ready checks
    task automatic req_step(input string nm, input logic [3:0] hv, input logic ar,
                            input logic [3:0] e_gnt);
        @(negedge clk);
        drive4(hv, ar, 1'b0, 8'h00, 4'hf);
        #1;
        chk({nm, " gnt"}, 32'(gnt4), 32'(e_gnt));
        chk({nm, " a_ready"}, 32'(ardy4()), 32'(e_gnt & {4{ar}}));
    endtask

    initial begin
        //           hv       ar    dv    ds     hdr      gnt      aval  asrc   addr    hdv
        //           dready hds
        vec[0] = '{4'b0000, 1'b1, 1'b0, 8'h00, 4'b1111, 4'b0000, 1'b0, 8'h00, 32'h000, 4'b0000,
                   1'b1, 8'h00};
        vec[1] = '{4'b0100, 1'b1, 1'b1, 8'h16, 4'b1111, 4'b0100, 1'b1, 8'h16, 32'h200, 4'b0100,
                   1'b1, 8'h05};
        vec[2] = '{4'b1111, 1'b1, 1'b0, 8'h16, 4'b1011, 4'b1000, 1'b1, 8'h17, 32'h300, 4'b0000,
                   1'b0, 8'h05};
        vec[3] = '{4'b1111, 1'b1, 1'b1, 8'h17, 4'b0111, 4'b0001, 1'b1, 8'h14, 32'h000, 4'b1000,
                   1'b0, 8'h05};
        vec[4] = '{4'b1111, 1'b1, 1'b1, 8'h20, 4'b1111, 4'b0010, 1'b1, 8'h15, 32'h100, 4'b0001,
                   1'b1, 8'h08};
        vec[5] = '{4'b1111, 1'b0, 1'b0, 8'h00, 4'b1111, 4'b0100, 1'b1, 8'h16, 32'h200, 4'b0000,
                   1'b1, 8'h00};
        vec[6] = '{4'b1111, 1'b1, 1'b0, 8'h00, 4'b1111, 4'b0100, 1'b1, 8'h16, 32'h200, 4'b0000,
                   1'b1, 8'h00};
        vec[7] = '{4'b0011, 1'b1, 1'b0, 8'h00, 4'b1111, 4'b0001, 1'b1, 8'h14, 32'h000, 4'b0000,
                   1'b1, 8'h00};
        vec[8] = '{4'b0001, 1'b1, 1'b0, 8'h00, 4'b1111, 4'b0001, 1'b1, 8'h14, 32'h000, 4'b0000,
                   1'b1, 8'h00};
        vec[9] = '{4'b0000, 1'b1, 1'b1, 8'h1b, 4'b0111, 4'b0000, 1'b0, 8'h00, 32'h000, 4'b1000,
                   1'b0, 8'h06};

        // Reset: outputs quiet even with hosts valid and a response on the bus
        rst = 1'b1;
        drive4(4'b1111, 1'b1, 1'b1, 8'h16, 4'b1111);
        drive3(1'b1, 8'h03, 3'b000);
        @(negedge clk);
        #1;
        chk("rst gnt", 32'(gnt4), 32'h0);
        chk("rst a_ready", 32'(ardy4()), 32'h0);
        chk("rst d_valid", 32'(dv4()), 32'h0);
        chk("rst dev a_valid", 32'(d4o.a_valid), 32'h0);
        chk("rst misroute", 32'(mis3), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive3(1'b0, 8'h00, 3'b111);

        // Table: grants, tagging and response routing on M=4
        for (int v = 0; v < 10; v++) begin
            drive4(vec[v].hv, vec[v].ar, vec[v].dv, vec[v].ds, vec[v].hdr);
            #1;
            chk($sformatf("v%0d gnt", v), 32'(gnt4), 32'(vec[v].e_gnt));
            chk($sformatf("v%0d a_valid", v), 32'(d4o.a_valid), 32'(vec[v].e_aval));
            chk($sformatf("v%0d a_source", v), 32'(d4o.a_source), 32'(vec[v].e_asrc));
            chk($sformatf("v%0d a_address", v), d4o.a_address, vec[v].e_addr);
            chk($sformatf("v%0d a_ready", v), 32'(ardy4()), 32'(vec[v].e_gnt & {4{vec[v].ar}}));
`ifndef TLUL_SOCKET_M1_RSP_REG_EN
            chk($sformatf("v%0d d_valid", v), 32'(dv4()), 32'(vec[v].e_hdv));
            chk($sformatf("v%0d d_ready", v), 32'(d4o.d_ready), 32'(vec[v].e_dready));
            chk($sformatf("v%0d d_source", v), 32'(h4o[0].d_source), 32'(vec[v].e_hds));
`endif
            @(negedge clk);
        end

        // Lock: host 1 stalls while higher-priority host 0 joins
        req_step("lk0", 4'b1000, 1'b1, 4'b1000);
        req_step("lk1", 4'b0010, 1'b0, 4'b0010);
        for (int c = 0; c < 4; c++) begin
            req_step($sformatf("lk_stall%0d", c), 4'b0011, 1'b0, 4'b0010);
        end
        req_step("lk_acc", 4'b0011, 1'b1, 4'b0010);
        req_step("lk_next", 4'b0001, 1'b1, 4'b0001);

        // Reset mid-stall: lock on host 3 is dropped and priority returns to 0
        req_step("rs_lock", 4'b1000, 1'b0, 4'b1000);
        @(negedge clk);
        rst = 1'b1;
        drive4(4'b1001, 1'b0, 1'b0, 8'h00, 4'hf);
        #1;
        chk("rs_during gnt", 32'(gnt4), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive4(4'b1001, 1'b0, 1'b0, 8'h00, 4'hf);
        #1;
        chk("rs_after gnt", 32'(gnt4), 32'b0001);
        req_step("rs_acc", 4'b1001, 1'b1, 4'b0001);

        // Misroute on M=3: tag 3 is sunk with d_ready high and a one-cycle pulse
        @(negedge clk);
        drive3(1'b1, 8'h03, 3'b000);
        #1;
        chk("mr d_ready", 32'(d3o.d_ready), 32'h1);
        chk("mr pulse", 32'(mis3), 32'h1);
        chk("mr d_valid", 32'(dv3()), 32'h0);
        @(negedge clk);
        drive3(1'b0, 8'h03, 3'b000);
        #1;
        chk("mr pulse end", 32'(mis3), 32'h0);
`ifndef TLUL_SOCKET_M1_RSP_REG_EN
        @(negedge clk);
        drive3(1'b1, 8'h02, 3'b011);
        #1;
        chk("m3 idx2 d_ready", 32'(d3o.d_ready), 32'h0);
        chk("m3 idx2 d_valid", 32'(dv3()), 32'b100);
        chk("m3 idx2 pulse", 32'(mis3), 32'h0);
`else
        // Registered response: hold under back-pressure, drain and refill together
        @(negedge clk);
        drive4(4'b0000, 1'b1, 1'b1, 8'h04, 4'b1110);
        #1;
        chk("rr cap d_ready", 32'(d4o.d_ready), 32'h1);
        chk("rr cap d_valid", 32'(dv4()), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive4(4'b0000, 1'b1, 1'b1, 8'h08, 4'b1110);
            #1;
            chk($sformatf("rr hold%0d d_ready", c), 32'(d4o.d_ready), 32'h0);
            chk($sformatf("rr hold%0d d_valid", c), 32'(dv4()), 32'b0001);
            chk($sformatf("rr hold%0d d_source", c), 32'(h4o[0].d_source), 32'h01);
        end
        @(negedge clk);
        drive4(4'b0000, 1'b1, 1'b1, 8'h08, 4'b1111);
        #1;
        chk("rr drain d_ready", 32'(d4o.d_ready), 32'h1);
        chk("rr drain d_source", 32'(h4o[0].d_source), 32'h01);
        @(negedge clk);
        drive4(4'b0000, 1'b1, 1'b0, 8'h00, 4'b1111);
        #1;
        chk("rr second d_valid", 32'(dv4()), 32'b0001);
        chk("rr second d_source", 32'(h4o[0].d_source), 32'h02);
        @(negedge clk);
        #1;
        chk("rr empty d_valid", 32'(dv4()), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
